// File: rtl/match_encoder.sv
// Two-stage priority encoder for a TCAM match-line vector: per-byte pre-encode,
// then lowest-group select, with valid/ready flow control and a saturating hit counter.
module match_encoder #(
  parameter int D  = 512,
  parameter int AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [D-1:0]  match_in,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_hit,
  output logic [AW-1:0] out_addr,
  output logic          out_multi,
  output logic [31:0]   hit_count
);

  localparam int G  = D / 8;
  localparam int GW = AW - 3;

  function automatic logic [2:0] lowest8(input logic [7:0] b);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (b[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic multi8(input logic [7:0] b);
    return |(b & (b - 8'd1));
  endfunction

  logic                 w_advance;
  logic [G-1:0]         w_ghit_p0;
  logic [G-1:0]         w_gmulti_p0;
  logic [G-1:0][2:0]    w_gidx_p0;

  logic                 r_vld_p1;
  logic [G-1:0]         r_ghit_p1;
  logic [G-1:0]         r_gmulti_p1;
  logic [G-1:0][2:0]    r_gidx_p1;

  logic                 w_hit_p1;
  logic                 w_multi_p1;
  logic [GW-1:0]        w_gsel_p1;
  logic [2:0]           w_lidx_p1;

  logic                 r_vld_p2;
  logic                 r_hit_p2;
  logic [AW-1:0]        r_addr_p2;
  logic                 r_multi_p2;
  logic [31:0]          r_hit_count;

  assign w_advance = !r_vld_p2 || out_ready;
  assign in_ready  = w_advance;

  // Stage p0 -> p1: per-byte hit, lowest local index, and in-byte multi flag
  always_comb begin
    w_ghit_p0   = '0;
    w_gmulti_p0 = '0;
    w_gidx_p0   = '0;
    for (int g = 0; g < G; g++) begin
      w_ghit_p0[g]   = |match_in[g*8 +: 8];
      w_gidx_p0[g]   = lowest8(match_in[g*8 +: 8]);
      w_gmulti_p0[g] = multi8(match_in[g*8 +: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (w_advance) begin
      r_ghit_p1   <= w_ghit_p0;
      r_gidx_p1   <= w_gidx_p0;
      r_gmulti_p1 <= w_gmulti_p0;
    end
  end

  // Stage p1 -> p2: lowest hitting byte wins; two hitting bytes also imply multi
  always_comb begin
    w_gsel_p1 = '0;
    w_lidx_p1 = '0;
    for (int g = G - 1; g >= 0; g--) begin
      if (r_ghit_p1[g]) begin
        w_gsel_p1 = GW'(g);
        w_lidx_p1 = r_gidx_p1[g];
      end
    end
    w_hit_p1   = |r_ghit_p1;
    w_multi_p1 = (|r_gmulti_p1) || (|(r_ghit_p1 & (r_ghit_p1 - 1'b1)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p1   <= 1'b0;
      r_vld_p2   <= 1'b0;
      r_hit_p2   <= 1'b0;
      r_addr_p2  <= '0;
      r_multi_p2 <= 1'b0;
    end else if (w_advance) begin
      r_vld_p1   <= in_valid;
      r_vld_p2   <= r_vld_p1;
      r_hit_p2   <= w_hit_p1;
      r_addr_p2  <= {w_gsel_p1, w_lidx_p1};
      r_multi_p2 <= w_multi_p1;
    end
  end

  // Output stage: counter advances only on delivered hits and sticks at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit_count <= '0;
    end else if (r_vld_p2 && out_ready && r_hit_p2 && (r_hit_count != 32'hFFFF_FFFF)) begin
      r_hit_count <= r_hit_count + 32'd1;
    end
  end

  assign out_valid = r_vld_p2;
  assign out_hit   = r_hit_p2;
  assign out_addr  = r_addr_p2;
  assign out_multi = r_multi_p2;
  assign hit_count = r_hit_count;

endmodule

// File: tb/tb_match_encoder.sv
// Bench for match_encoder: bit-scan reference model with an in-order result queue,
// checked every cycle, plus directed vectors with literal expectations.
module tb_match_encoder;
  localparam int D  = 512;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic [D-1:0]  match_in;
  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic          out_hit;
  logic [AW-1:0] out_addr;
  logic          out_multi;
  logic [31:0]   hit_count;

  match_encoder #(.D(D), .AW(AW)) dut (
    .clk(clk), .reset(reset), .match_in(match_in), .in_valid(in_valid),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_hit(out_hit), .out_addr(out_addr), .out_multi(out_multi),
    .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          hit;
    logic [AW-1:0] addr;
    logic          multi;
  } res_t;

  res_t        q[$];
  logic [31:0] mcnt;
  logic        preload;
  int          errs;
  int          checks;

  function automatic res_t model(input logic [D-1:0] m);
    res_t r;
    int   n;
    r = '0;
    n = 0;
    for (int i = 0; i < D; i++) begin
      if (m[i]) begin
        if (n == 0) r.addr = AW'(i);
        n++;
      end
    end
    r.hit   = (n > 0);
    r.multi = (n >= 2);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sampled on the rising edge, before the DUT's registers update
  task automatic monitor();
    res_t r;
    if (reset) begin
      q.delete();
      mcnt = '0;
      return;
    end
    if (preload) mcnt = 32'hFFFF_FFFE;
    chk("in_ready", in_ready, !(out_valid && !out_ready));
    chk("hit_count", hit_count, mcnt);
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", out_valid, 1'b0);
      end else begin
        chk("out_hit", out_hit, q[0].hit);
        chk("out_addr", out_addr, q[0].addr);
        chk("out_multi", out_multi, q[0].multi);
        if (out_ready) begin
          r = q.pop_front();
          if (r.hit && mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 32'd1;
        end
      end
    end
    if (in_valid && in_ready) q.push_back(model(match_in));
  endtask

  task automatic step();
    @(posedge clk);
    monitor();
    @(negedge clk);
  endtask

  task automatic single(input logic [D-1:0] m, input string nm,
                        input logic ehit, input logic [AW-1:0] eaddr, input logic emulti);
    match_in  = m;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk({nm, "_valid"}, out_valid, 1'b1);
    chk({nm, "_hit"}, out_hit, ehit);
    chk({nm, "_addr"}, out_addr, eaddr);
    chk({nm, "_multi"}, out_multi, emulti);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [D-1:0] m;
    logic [3:0]   pat;
    logic         acc;
    int           k;
    int           cyc;
    errs = 0; checks = 0; mcnt = '0; preload = 1'b0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; match_in = '0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_out_addr", out_addr, 9'd0);
    chk("rst_out_hit", out_hit, 1'b0);
    step();
    reset = 1'b0;
    #1 chk("post_rst_in_ready", in_ready, 1'b1);

    m = '0; m[300] = 1'b1;
    single(m, "hit300", 1'b1, 9'd300, 1'b0);
    chk("hit300_count", hit_count, 32'd1);

    m = '0; m[7] = 1'b1; m[8] = 1'b1; m[511] = 1'b1;
    single(m, "b7_8_511", 1'b1, 9'd7, 1'b1);
    m = '0; m[9] = 1'b1; m[10] = 1'b1;
    single(m, "b9_10", 1'b1, 9'd9, 1'b1);
    m = '1;
    single(m, "all_ones", 1'b1, 9'd0, 1'b1);
    m = '0; m[511] = 1'b1;
    single(m, "b511", 1'b1, 9'd511, 1'b0);
    m = '0;
    single(m, "miss", 1'b0, 9'd0, 1'b0);
    chk("miss_count", hit_count, 32'd5);

    // Backpressure stream, addresses 0..9
    pat = 4'b1001;
    k = 0; cyc = 0;
    while (k < 10 && cyc < 200) begin
      m = '0; m[k] = 1'b1;
      match_in  = m;
      in_valid  = 1'b1;
      out_ready = pat[cyc % 4];
      #1 acc = in_ready;
      step();
      if (acc) k++;
      cyc++;
    end
    chk("bp_accepted", k, 10);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() > 0; i++) step();
    chk("bp_drained", q.size(), 0);
    chk("bp_count", hit_count, 32'd15);

    // Reset with two results in flight
    m = '0; m[20] = 1'b1; match_in = m; in_valid = 1'b1; out_ready = 1'b1;
    step();
    m = '0; m[21] = 1'b1; match_in = m;
    step();
    in_valid = 1'b0;
    chk("inflight_valid", out_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_hit_count", hit_count, 32'd0);
    chk("midrst_out_addr", out_addr, 9'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("no_stale", out_valid, 1'b0);
    end

    // Saturation from a preloaded counter
    force dut.r_hit_count = 32'hFFFF_FFFE;
    preload = 1'b1;
    step();
    release dut.r_hit_count;
    preload = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      m = '0; m[i] = 1'b1; match_in = m;
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("sat_count", hit_count, 32'hFFFF_FFFF);
    chk("sat_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
